// File: rtl/morse_letter_sequencer_pkg.sv
// Shared types, widths and the A..Z Morse lookup for the letter sequencer.
// Patterns are stored LSB-first: the first symbol of the letter is emitted first.
package morse_letter_sequencer_pkg;

   localparam int unsigned MORSE_W = 13;
   localparam int unsigned LEN_W   = 4;
   localparam logic [4:0]  NUM_LETTERS = 5'd26;

   typedef enum logic [1:0] {
      StIdle,
      StEmit,
      StGap
   } state_e;

   // Returns {len, pattern}; dot = "1", dash = "111", symbols separated by one "0".
   function automatic logic [LEN_W+MORSE_W-1:0] morse_lut(input logic [4:0] letter);
      logic [6:0]         code;  // {symbol count, dash mask with bit i = symbol i}
      logic [2:0]         nsym;
      logic [3:0]         dash;
      logic [MORSE_W-1:0] pat;
      int                 pos;
      code = 7'd0;
      pat  = '0;
      pos  = 0;
      case (letter)
         5'd0:  code = {3'd2, 4'b0010};  // A .-
         5'd1:  code = {3'd4, 4'b0001};  // B -...
         5'd2:  code = {3'd4, 4'b0101};  // C -.-.
         5'd3:  code = {3'd3, 4'b0001};  // D -..
         5'd4:  code = {3'd1, 4'b0000};  // E .
         5'd5:  code = {3'd4, 4'b0100};  // F ..-.
         5'd6:  code = {3'd3, 4'b0011};  // G --.
         5'd7:  code = {3'd4, 4'b0000};  // H ....
         5'd8:  code = {3'd2, 4'b0000};  // I ..
         5'd9:  code = {3'd4, 4'b1110};  // J .---
         5'd10: code = {3'd3, 4'b0101};  // K -.-
         5'd11: code = {3'd4, 4'b0010};  // L .-..
         5'd12: code = {3'd2, 4'b0011};  // M --
         5'd13: code = {3'd2, 4'b0001};  // N -.
         5'd14: code = {3'd3, 4'b0111};  // O ---
         5'd15: code = {3'd4, 4'b0110};  // P .--.
         5'd16: code = {3'd4, 4'b1011};  // Q --.-
         5'd17: code = {3'd3, 4'b0010};  // R .-.
         5'd18: code = {3'd3, 4'b0000};  // S ...
         5'd19: code = {3'd1, 4'b0001};  // T -
         5'd20: code = {3'd3, 4'b0100};  // U ..-
         5'd21: code = {3'd4, 4'b1000};  // V ...-
         5'd22: code = {3'd3, 4'b0110};  // W .--
         5'd23: code = {3'd4, 4'b1001};  // X -..-
         5'd24: code = {3'd4, 4'b1101};  // Y -.--
         5'd25: code = {3'd4, 4'b0011};  // Z --..
         default: code = 7'd0;
      endcase
      nsym = code[6:4];
      dash = code[3:0];
      for (int i = 0; i < 4; i++) begin
         if (i < int'(nsym)) begin
            if (i > 0) pos = pos + 1;
            if (dash[i]) begin
               pat[pos]   = 1'b1;
               pat[pos+1] = 1'b1;
               pat[pos+2] = 1'b1;
               pos = pos + 3;
            end else begin
               pat[pos] = 1'b1;
               pos = pos + 1;
            end
         end
      end
      return {LEN_W'(pos), pat};
   endfunction

endpackage

// File: rtl/morse_letter_sequencer_if.sv
// Request/status bundle between a letter source and the Morse sequencer.
interface morse_letter_sequencer_if;
   logic       start;
   logic [4:0] letter;
   logic       led;
   logic       busy;
   logic       done;

   modport master (output start, output letter, input led, input busy, input done);
   modport slave  (input start, input letter, output led, output busy, output done);
endinterface

// File: rtl/morse_letter_sequencer_unit_tick.sv
// Morse unit timebase: counts 0..TICK_DIV-1 and pulses tick_o on the wrap cycle.
module morse_letter_sequencer_unit_tick #(
   parameter int unsigned TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || cnt_q == CntMax) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = !clear_i && (cnt_q == CntMax);

endmodule

// File: rtl/morse_letter_sequencer.sv
// Plays one letter LSB-first on led, one bit per unit, then a 3-unit gap and a done pulse.
module morse_letter_sequencer
   import morse_letter_sequencer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 25_000_000
) (
   input  logic                     clk,
   input  logic                     reset,
   morse_letter_sequencer_if.slave  bus
);

   state_e             state_d, state_q;
   logic [MORSE_W-1:0] shreg_d, shreg_q;
   logic [LEN_W-1:0]   cnt_d, cnt_q;
   logic               done_d, done_q;
   logic [MORSE_W-1:0] lut_pat;
   logic [LEN_W-1:0]   lut_len;
   logic               tick;

   assign {lut_len, lut_pat} = morse_lut(bus.letter);

   // Held in clear while idle so the first unit after acceptance is full length.
   morse_letter_sequencer_unit_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_unit_tick (
      .clk     (clk),
      .reset   (reset),
      .clear_i (state_q == StIdle),
      .tick_o  (tick)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start && bus.letter < NUM_LETTERS) begin
               state_d = StEmit;
               shreg_d = lut_pat;
               cnt_d   = lut_len;
            end
         end
         StEmit: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (cnt_q == LEN_W'(1)) begin
                  state_d = StGap;
                  cnt_d   = LEN_W'(3);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         StGap: begin
            if (tick) begin
               if (cnt_q == LEN_W'(1)) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign bus.led  = (state_q == StEmit) && shreg_q[0];
   assign bus.busy = (state_q != StIdle);
   assign bus.done = done_q;

endmodule
